// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: op encodings, branch funct3 codes, FSM states.
package branch_unit_pkg;
  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_FLUSH} state_e;
endpackage

// File: rtl/branch_unit_if.sv
// Request handshake and result/redirect bus between EX control and the branch unit.
interface branch_unit_if;
  logic        br_valid;
  logic        br_ready;
  logic [1:0]  br_op;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_link;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal;
  logic        misalign;

  modport master (
    output br_valid, br_op, br_funct3, br_pc, br_imm, rs1, rs2,
    input  br_ready, res_valid, res_taken, res_link, redirect_valid,
           redirect_pc, flush, illegal, misalign
  );

  modport slave (
    input  br_valid, br_op, br_funct3, br_pc, br_imm, rs1, rs2,
    output br_ready, res_valid, res_taken, res_link, redirect_valid,
           redirect_pc, flush, illegal, misalign
  );
endinterface

// File: rtl/branch_comp.sv
// Shared comparator: equality and signed/unsigned less-than.
module branch_comp (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        brUn,
  output logic        eq,
  output logic        lt
);
  assign eq = (A == B);
  assign lt = brUn ? (A < B) : ($signed(A) < $signed(B));
endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution: accept op, resolve on registered operands, redirect and squash.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_unit_if.slave     bus,
  input  logic             br_kill,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_taken
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e           r_state;
  logic             r_ready;
  logic [1:0]       r_op;
  logic [2:0]       r_f3;
  logic [31:0]      r_pc, r_imm, r_rs1, r_rs2;
  logic             r_res_valid, r_res_taken, r_illegal, r_misalign;
  logic [31:0]      r_res_link, r_redir_pc;
  logic             r_redir_valid, r_flush;
  logic [FW-1:0]    r_fcnt;
  logic [CNT_W-1:0] r_cnt_res, r_cnt_tk;

  logic        w_eq, w_lt, w_cond, w_illegal, w_taken_raw, w_misalign, w_taken;
  logic [31:0] w_target, w_link;

  branch_comp u_comp (
    .A    (r_rs1),
    .B    (r_rs2),
    .brUn (r_f3[1]),
    .eq   (w_eq),
    .lt   (w_lt)
  );

  // Decode the branch condition and legality from the registered op.
  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (r_f3)
      F3_BEQ:           w_cond = w_eq;
      F3_BNE:           w_cond = ~w_eq;
      F3_BLT, F3_BLTU:  w_cond = w_lt;
      F3_BGE, F3_BGEU:  w_cond = ~w_lt;
      default:          w_illegal = (r_op == OP_BR);
    endcase
    if (r_op == OP_RSV) w_illegal = 1'b1;
  end

  // JALR clears bit0; everything else is pc-relative. Adds wrap mod 2^32.
  assign w_target    = (r_op == OP_JALR) ? ((r_rs1 + r_imm) & ~32'h1) : (r_pc + r_imm);
  assign w_link      = r_pc + 32'd4;
  assign w_taken_raw = ~w_illegal & ((r_op == OP_JAL) | (r_op == OP_JALR) |
                                     ((r_op == OP_BR) & w_cond));
  // A misaligned taken target becomes an exception rather than a redirect.
  assign w_misalign  = w_taken_raw & w_target[1];
  assign w_taken     = w_taken_raw & ~w_misalign;

  // FSM with registered outputs, flush down-counter and perf counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_op          <= '0;
      r_f3          <= '0;
      r_pc          <= '0;
      r_imm         <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_illegal     <= 1'b0;
      r_misalign    <= 1'b0;
      r_res_link    <= '0;
      r_redir_pc    <= '0;
      r_redir_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_fcnt        <= '0;
      r_cnt_res     <= '0;
      r_cnt_tk      <= '0;
    end else begin
      r_res_valid   <= 1'b0;
      r_redir_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A kill in the same cycle blocks acceptance of the offer.
          if (bus.br_valid && r_ready && !br_kill) begin
            r_op    <= bus.br_op;
            r_f3    <= bus.br_funct3;
            r_pc    <= bus.br_pc;
            r_imm   <= bus.br_imm;
            r_rs1   <= bus.rs1;
            r_rs2   <= bus.rs2;
            r_ready <= 1'b0;
            r_state <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          if (br_kill) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_res_valid <= 1'b1;
            r_res_taken <= w_taken;
            r_res_link  <= w_link;
            r_illegal   <= w_illegal;
            r_misalign  <= w_misalign;
            r_redir_pc  <= w_target;
            r_cnt_res   <= r_cnt_res + 1'b1;
            if (w_taken) begin
              r_redir_valid <= 1'b1;
              r_flush       <= 1'b1;
              r_fcnt        <= FW'(FLUSH_CYCLES - 1);
              r_cnt_tk      <= r_cnt_tk + 1'b1;
              r_state       <= S_FLUSH;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          // The redirect cycle already counted as the first flush cycle.
          if (r_fcnt == '0) begin
            r_flush <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt - 1'b1;
          end
        end
        default: begin
          r_flush <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.br_ready       = r_ready;
  assign bus.res_valid      = r_res_valid;
  assign bus.res_taken      = r_res_taken;
  assign bus.res_link       = r_res_link;
  assign bus.redirect_valid = r_redir_valid;
  assign bus.redirect_pc    = r_redir_pc;
  assign bus.flush          = r_flush;
  assign bus.illegal        = r_illegal;
  assign bus.misalign       = r_misalign;
  assign cnt_resolved       = r_cnt_res;
  assign cnt_taken          = r_cnt_tk;
endmodule
